// File: rtl/alarm_unit_if.sv
// ---------------------------------------------------------------------------
// alarm_unit_if
// Bundle between the clock/button front end and the alarm stage.
//   data_ch    : current BCD time {Ht,Hu,Mt,Mu,St,Su}
//   rezhim     : current display/mode index
//   button     : one-cycle debounced pulses, [1] edit, [2] inc/snooze, [3] arm/stop
//   alarm_data : {alarm HH, alarm MM, 8'h00} for the 7-segment block
//   edit_field : 00 none, 01 hours, 10 minutes
//   ring       : alarm sounding
//   led        : [0] armed, [1] ring, [2] snooze, [3] editing
// master = time/button source and display sink, slave = alarm_unit.
// ---------------------------------------------------------------------------
interface alarm_unit_if;
    logic [23:0] data_ch;
    logic [1:0]  rezhim;
    logic [0:3]  button;
    logic [23:0] alarm_data;
    logic [1:0]  edit_field;
    logic        ring;
    logic [3:0]  led;

    modport master (
        output data_ch, rezhim, button,
        input  alarm_data, edit_field, ring, led
    );

    modport slave (
        input  data_ch, rezhim, button,
        output alarm_data, edit_field, ring, led
    );
endinterface

// File: rtl/alarm_unit.sv
// ---------------------------------------------------------------------------
// alarm_unit
// Alarm stage behind the real-time clock core. Holds a user-set HH:MM alarm,
// compares it with the running time and drives ring/LED/display outputs.
// The seconds tick is derived from any change of the seconds-units digit.
//
// Ports:
//   clock : system clock
//   reset : asynchronous, active-low reset
//   bus   : alarm_unit_if.slave (data_ch, rezhim, button in;
//           alarm_data, edit_field, ring, led out; all outputs registered)
//
// Optional feature macro: ALARM_BLINK_EN
//   defined   -> 2 Hz phase from CLK_HZ gates ring/led[1] while ringing and
//                blinks led[3] while editing
//   undefined -> ring and led are steady levels
// ---------------------------------------------------------------------------
module alarm_unit #(
    parameter logic [1:0] MODE_ID    = 2'd3,
    parameter int         RING_SEC   = 60,
    parameter int         SNOOZE_SEC = 300,
    parameter int         CLK_HZ     = 50000000
) (
    input  logic         clock,
    input  logic         reset,
    alarm_unit_if.slave  bus
);

    localparam int CNT_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RING_LIM = CNT_W'(RING_SEC);
    localparam logic [CNT_W-1:0] SNZ_LIM  = CNT_W'(SNOOZE_SEC);

    typedef enum logic [2:0] {
        S_DISARMED, S_EDIT_H, S_EDIT_M, S_ARMED, S_RINGING, S_SNOOZE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_prev_su;
    logic [7:0]       r_alarm_hh, r_alarm_mm, w_hh_nxt, w_mm_nxt;
    logic [CNT_W-1:0] r_ring_cnt, r_snooze_cnt, w_ring_cnt_nxt, w_snooze_cnt_nxt;
    logic             r_ring;
    logic [3:0]       r_led;
    logic [1:0]       r_edit_field;

    logic w_sec_tick, w_match, w_in_mode, w_btn1, w_btn2, w_btn3;
    logic w_ringing_nxt, w_armed_nxt, w_edit_nxt, w_phase;
    logic w_unused;

    // Hours wrap 23 -> 00; units digit carries at 9.
    function automatic logic [7:0] bcd_inc_hh(input logic [7:0] v);
        if (v == 8'h23)          return 8'h00;
        else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                     return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Minutes wrap 59 -> 00.
    function automatic logic [7:0] bcd_inc_mm(input logic [7:0] v);
        if (v == 8'h59)          return 8'h00;
        else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                     return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign w_sec_tick = (bus.data_ch[3:0] != r_prev_su);
    // Only the tick onto :00 can match, so each alarm minute fires once.
    assign w_match    = w_sec_tick && (bus.data_ch[23:8] == {r_alarm_hh, r_alarm_mm})
                        && (bus.data_ch[7:0] == 8'h00);
    assign w_in_mode  = (bus.rezhim == MODE_ID);
    assign w_btn1     = bus.button[1];
    assign w_btn2     = bus.button[2];
    assign w_btn3     = bus.button[3];
    assign w_unused   = &{1'b0, bus.button[0], (CLK_HZ > 0)};

    always_comb begin
        w_state_nxt      = r_state;
        w_hh_nxt         = r_alarm_hh;
        w_mm_nxt         = r_alarm_mm;
        w_ring_cnt_nxt   = r_ring_cnt;
        w_snooze_cnt_nxt = r_snooze_cnt;
        case (r_state)
            S_DISARMED: begin
                if (w_in_mode && w_btn3)      w_state_nxt = S_ARMED;
                else if (w_in_mode && w_btn1) w_state_nxt = S_EDIT_H;
            end
            S_EDIT_H: begin
                if (!w_in_mode)  w_state_nxt = S_DISARMED;
                else if (w_btn2) w_hh_nxt = bcd_inc_hh(r_alarm_hh);
                else if (w_btn1) w_state_nxt = S_EDIT_M;
            end
            S_EDIT_M: begin
                if (!w_in_mode)  w_state_nxt = S_DISARMED;
                else if (w_btn2) w_mm_nxt = bcd_inc_mm(r_alarm_mm);
                else if (w_btn1) w_state_nxt = S_DISARMED;
            end
            S_ARMED: begin
                if (w_in_mode && w_btn3)      w_state_nxt = S_DISARMED;
                else if (w_in_mode && w_btn1) w_state_nxt = S_EDIT_H;
                else if (w_match) begin
                    w_state_nxt    = S_RINGING;
                    w_ring_cnt_nxt = '0;
                end
            end
            S_RINGING: begin
                // Buttons here act in any display mode so the alarm can always be silenced.
                if (w_btn3) w_state_nxt = S_ARMED;
                else if (w_btn2) begin
                    w_state_nxt      = S_SNOOZE;
                    w_snooze_cnt_nxt = '0;
                end
                else if (w_btn1) w_state_nxt = S_ARMED;
                else if (w_sec_tick) begin
                    w_ring_cnt_nxt = sat_inc(r_ring_cnt);
                    if (w_ring_cnt_nxt >= RING_LIM) w_state_nxt = S_ARMED;
                end
            end
            S_SNOOZE: begin
                if (w_btn3) w_state_nxt = S_ARMED;
                else if (w_sec_tick) begin
                    w_snooze_cnt_nxt = sat_inc(r_snooze_cnt);
                    if (w_snooze_cnt_nxt >= SNZ_LIM) begin
                        w_state_nxt    = S_RINGING;
                        w_ring_cnt_nxt = '0;
                    end
                end
            end
            default: w_state_nxt = S_DISARMED;
        endcase
    end

    assign w_ringing_nxt = (w_state_nxt == S_RINGING);
    assign w_armed_nxt   = (w_state_nxt == S_ARMED) || w_ringing_nxt || (w_state_nxt == S_SNOOZE);
    assign w_edit_nxt    = (w_state_nxt == S_EDIT_H) || (w_state_nxt == S_EDIT_M);

`ifdef ALARM_BLINK_EN
    // Toggle every quarter second -> 2 Hz square phase.
    localparam int PRE_MAX = (CLK_HZ / 4 > 1) ? (CLK_HZ / 4 - 1) : 1;
    localparam int PRE_W   = $clog2(PRE_MAX + 1);
    localparam logic [PRE_W-1:0] PRE_LIM = PRE_W'(PRE_MAX);

    logic [PRE_W-1:0] r_pre_cnt, w_pre_nxt;
    logic             r_phase;
    logic             w_ring_entry;

    assign w_ring_entry = w_ringing_nxt && (r_state != S_RINGING);

    always_comb begin
        w_pre_nxt = r_pre_cnt + 1'b1;
        w_phase   = r_phase;
        // Restart on entry to ringing so the first beep starts at once.
        if (w_ring_entry) begin
            w_pre_nxt = '0;
            w_phase   = 1'b1;
        end else if (r_pre_cnt == PRE_LIM) begin
            w_pre_nxt = '0;
            w_phase   = ~r_phase;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pre_cnt <= '0;
            r_phase   <= 1'b0;
        end else begin
            r_pre_cnt <= w_pre_nxt;
            r_phase   <= w_phase;
        end
    end
`else
    assign w_phase = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_DISARMED;
            r_prev_su    <= 4'd0;
            r_alarm_hh   <= 8'h06;
            r_alarm_mm   <= 8'h00;
            r_ring_cnt   <= '0;
            r_snooze_cnt <= '0;
            r_ring       <= 1'b0;
            r_led        <= 4'b0000;
            r_edit_field <= 2'b00;
        end else begin
            r_state      <= w_state_nxt;
            r_prev_su    <= bus.data_ch[3:0];
            r_alarm_hh   <= w_hh_nxt;
            r_alarm_mm   <= w_mm_nxt;
            r_ring_cnt   <= w_ring_cnt_nxt;
            r_snooze_cnt <= w_snooze_cnt_nxt;
            r_ring       <= w_ringing_nxt & w_phase;
            r_led        <= {w_edit_nxt & w_phase, (w_state_nxt == S_SNOOZE),
                             w_ringing_nxt & w_phase, w_armed_nxt};
            r_edit_field <= (w_state_nxt == S_EDIT_H) ? 2'b01 :
                            (w_state_nxt == S_EDIT_M) ? 2'b10 : 2'b00;
        end
    end

    assign bus.alarm_data = {r_alarm_hh, r_alarm_mm, 8'h00};
    assign bus.edit_field = r_edit_field;
    assign bus.ring       = r_ring;
    assign bus.led        = r_led;

endmodule
